// File: rtl/control_unit.sv
// control_unit: Moore sequencing FSM driving PC, IR, data memory, register file and ALU.
// Ports: clk/rst (async active-high), run (start, sampled in INIT), IR (current instruction);
// PC_clr/PC_inc, I_rd/IR_ld, D_addr/D_rd/D_wr, RF_s/RF_W_data/RF_W_addr/RF_W_wr,
// RF_Rp_addr/RF_Rp_rd, RF_Rq_addr/RF_Rq_rd, alu_s0, halted.
module control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] IR,
  output logic        PC_clr,
  output logic        PC_inc,
  output logic        I_rd,
  output logic        IR_ld,
  output logic [7:0]  D_addr,
  output logic        D_rd,
  output logic        D_wr,
  output logic [1:0]  RF_s,
  output logic [7:0]  RF_W_data,
  output logic [3:0]  RF_W_addr,
  output logic        RF_W_wr,
  output logic [3:0]  RF_Rp_addr,
  output logic        RF_Rp_rd,
  output logic [3:0]  RF_Rq_addr,
  output logic        RF_Rq_rd,
  output logic [2:0]  alu_s0,
  output logic        halted
);
  localparam logic [3:0] INIT   = 4'd0;
  localparam logic [3:0] FETCH  = 4'd1;
  localparam logic [3:0] DECODE = 4'd2;
  localparam logic [3:0] NOOP   = 4'd3;
  localparam logic [3:0] LOAD_A = 4'd4;
  localparam logic [3:0] LOAD_B = 4'd5;
  localparam logic [3:0] STORE  = 4'd6;
  localparam logic [3:0] ADD    = 4'd7;
  localparam logic [3:0] SUB    = 4'd8;
  localparam logic [3:0] LOADC  = 4'd9;
  localparam logic [3:0] HALT   = 4'd10;
  logic [3:0] state_q, state_d, dec;
  logic ld, st, ar, lc;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= INIT;
    else     state_q <= state_d;
  always_comb begin
    dec = NOOP;
    case (IR[15:12])
      4'h1:    dec = LOAD_A;
      4'h2:    dec = STORE;
      4'h3:    dec = ADD;
      4'h4:    dec = LOADC;
      4'h5:    dec = SUB;
      4'hF:    dec = HALT;
      default: dec = NOOP;
    endcase
  end
  always_comb begin
    state_d = FETCH;
    case (state_q)
      INIT:    state_d = run ? FETCH : INIT;
      FETCH:   state_d = DECODE;
      DECODE:  state_d = dec;
      LOAD_A:  state_d = LOAD_B;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end
  assign ld         = state_q == LOAD_A || state_q == LOAD_B;
  assign st         = state_q == STORE;
  assign ar         = state_q == ADD || state_q == SUB;
  assign lc         = state_q == LOADC;
  assign PC_clr     = state_q == INIT;
  assign PC_inc     = state_q == FETCH;
  assign I_rd       = state_q == FETCH;
  assign IR_ld      = state_q == FETCH;
  assign D_addr     = (ld || st) ? IR[7:0] : 8'h00;
  assign D_rd       = ld;
  assign D_wr       = st;
  assign RF_s       = ld ? 2'b01 : lc ? 2'b10 : 2'b00;
  assign RF_W_data  = lc ? IR[7:0] : 8'h00;
  assign RF_W_addr  = (ld || ar || lc) ? IR[11:8] : 4'h0;
  assign RF_W_wr    = state_q == LOAD_B || ar || lc;
  assign RF_Rp_addr = st ? IR[11:8] : ar ? IR[7:4] : 4'h0;
  assign RF_Rp_rd   = st || ar;
  assign RF_Rq_addr = ar ? IR[3:0] : 4'h0;
  assign RF_Rq_rd   = ar;
  assign alu_s0     = state_q == ADD ? 3'b001 : state_q == SUB ? 3'b010 : 3'b000;
  assign halted     = state_q == HALT;
endmodule
